peripheral_msi_cdc_tx_wb: RTL and testbench



---
 rtl/peripheral_msi_pkg_wb.sv | 15 +
 rtl/peripheral_msi_sync2_pgen_wb.sv | 30 +++
 rtl/peripheral_msi_cdc_tx_wb.sv | 99 +++++++++
 tb/tb_peripheral_msi_cdc_tx_wb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_msi_pkg_wb.sv
// Shared definitions for the Wishbone CDC toggle-handshake transmit path.
//   tx_state_e : transmit FSM state (IDLE = nothing outstanding, WAIT = request outstanding)
//   SYNC_DEPTH : flops in each toggle synchronizer. Round trip of one word is
//                roughly SYNC_DEPTH far-side cycles + SYNC_DEPTH near-side cycles
//                + one edge-detect cycle on each side.
package peripheral_msi_pkg_wb;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } tx_state_e;

  localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/peripheral_msi_sync2_pgen_wb.sv
// Toggle synchronizer with edge-to-pulse conversion.
//   c   : destination clock
//   rst : synchronous active-high reset
//   d   : toggle level from another clock domain
//   p   : one-cycle pulse per edge of d, SYNC_DEPTH cycles after capture
module peripheral_msi_sync2_pgen_wb
  import peripheral_msi_pkg_wb::*;
(
  input  logic c,
  input  logic rst,
  input  logic d,
  output logic p
);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  r_last;

  always_ff @(posedge c) begin
    if (rst) begin
      r_sync <= '0;
      r_last <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], d};
      r_last <= r_sync[SYNC_DEPTH-1];
    end
  end

  assign p = r_sync[SYNC_DEPTH-1] ^ r_last;

endmodule

// File: rtl/peripheral_msi_cdc_tx_wb.sv
// Transmit end of the toggle-handshake crossing. Words accepted on aen && ardy
// are presented on tx_data with a toggle on tx_req; tx_data stays frozen until
// the far side toggles tx_ack back. With PENDING=1 one extra word can wait in a
// holding register while another is in flight.
//   aclk, arst      : clock, synchronous active-high reset
//   adata, aen, ardy: source-side valid/ready input
//   tx_data, tx_req : held word and request toggle to far domain
//   tx_ack          : acknowledge toggle from far domain (asynchronous)
//   busy            : request outstanding or word held
//   ack_err         : pulse on acknowledge with nothing outstanding
module peripheral_msi_cdc_tx_wb
  import peripheral_msi_pkg_wb::*;
#(
  parameter int DW      = 32,
  parameter int PENDING = 1
) (
  input  logic          aclk,
  input  logic          arst,
  input  logic [DW-1:0] adata,
  input  logic          aen,
  output logic          ardy,
  output logic [DW-1:0] tx_data,
  output logic          tx_req,
  input  logic          tx_ack,
  output logic          busy,
  output logic          ack_err
);

  tx_state_e     r_state;
  logic          r_tx_req;
  logic [DW-1:0] r_tx_data;
  logic [DW-1:0] r_hold_data;
  logic          r_hold_valid;
  logic          r_ack_err;

  logic          w_ack_p;
  logic          w_ardy;
  logic          w_accept;

  peripheral_msi_sync2_pgen_wb u_ack_sync (
    .c   (aclk),
    .rst (arst),
    .d   (tx_ack),
    .p   (w_ack_p)
  );

  // Ready depends only on registered state, never on aen or the ack path.
  assign w_ardy   = (PENDING != 0) ? !r_hold_valid : (r_state == IDLE);
  assign w_accept = aen && w_ardy;

  always_ff @(posedge aclk) begin
    if (arst) begin
      r_state      <= IDLE;
      r_tx_req     <= 1'b0;
      r_tx_data    <= '0;
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
      r_ack_err    <= 1'b0;
    end else begin
      r_ack_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ack_err <= w_ack_p;
          if (w_accept) begin
            r_tx_data <= adata;
            r_tx_req  <= ~r_tx_req;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (w_ack_p) begin
            if (r_hold_valid) begin
              r_tx_data    <= r_hold_data;
              r_tx_req     <= ~r_tx_req;
              r_hold_valid <= 1'b0;
            end else if (w_accept) begin
              // Hold is empty: the word accepted this cycle launches directly.
              r_tx_data <= adata;
              r_tx_req  <= ~r_tx_req;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_accept) begin
            // Only reachable with PENDING=1, ardy is low in WAIT otherwise.
            r_hold_data  <= adata;
            r_hold_valid <= 1'b1;
          end
        end
      endcase
    end
  end

  assign ardy    = w_ardy;
  assign tx_data = r_tx_data;
  assign tx_req  = r_tx_req;
  assign busy    = (r_state == WAIT) || r_hold_valid;
  assign ack_err = r_ack_err;

endmodule

// File: tb/tb_peripheral_msi_cdc_tx_wb.sv
module tb_peripheral_msi_cdc_tx_wb;

  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic [31:0] adata   [2];
  logic        aen     [2];
  logic        ardy    [2];
  logic [31:0] tx_data [2];
  logic        tx_req  [2];
  logic        tx_ack  [2];
  logic        busy    [2];
  logic        ack_err [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  // instance 0: PENDING=1, instance 1: PENDING=0
  peripheral_msi_cdc_tx_wb #(.DW(32), .PENDING(1)) u_dut0 (
    .aclk(aclk), .arst(arst), .adata(adata[0]), .aen(aen[0]), .ardy(ardy[0]),
    .tx_data(tx_data[0]), .tx_req(tx_req[0]), .tx_ack(tx_ack[0]),
    .busy(busy[0]), .ack_err(ack_err[0])
  );

  peripheral_msi_cdc_tx_wb #(.DW(32), .PENDING(0)) u_dut1 (
    .aclk(aclk), .arst(arst), .adata(adata[1]), .aen(aen[1]), .ardy(ardy[1]),
    .tx_data(tx_data[1]), .tx_req(tx_req[1]), .tx_ack(tx_ack[1]),
    .busy(busy[1]), .ack_err(ack_err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: is a word in flight, which word, request level, a queue of
  // waiting words (capacity 1 or 0), and the last three tx_ack samples so that
  // the acknowledge is seen two edges after capture plus one edge detect.
  bit          m_valid = 0;
  bit          m_flight [2];
  bit          m_req    [2];
  logic [31:0] m_data   [2];
  bit          m_err    [2];
  bit          m_h1 [2], m_h2 [2], m_h3 [2];
  logic [31:0] m_hold [2][$];
  logic [31:0] acc_q  [2][$];
  logic [31:0] rx_q   [2][$];

  function automatic int cap(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic bit m_ardy(input int i);
    if (cap(i) > 0) return m_hold[i].size() < cap(i);
    return !m_flight[i];
  endfunction

  task automatic launch(input int i, input logic [31:0] w);
    m_data[i]   = w;
    m_req[i]    = !m_req[i];
    m_flight[i] = 1;
  endtask

  task automatic step(input int i);
    bit ackp, acc;
    if (arst) begin
      m_flight[i] = 0; m_req[i] = 0; m_data[i] = 0; m_err[i] = 0;
      m_h1[i] = 0; m_h2[i] = 0; m_h3[i] = 0;
      m_hold[i].delete();
      acc_q[i].delete();
      return;
    end
    ackp = m_h2[i] ^ m_h3[i];
    acc  = aen[i] && m_ardy(i);
    m_h3[i] = m_h2[i]; m_h2[i] = m_h1[i]; m_h1[i] = tx_ack[i];
    m_err[i] = 0;
    if (acc) acc_q[i].push_back(adata[i]);
    if (!m_flight[i]) begin
      m_err[i] = ackp;
      if (acc) launch(i, adata[i]);
    end else if (ackp) begin
      if (m_hold[i].size() > 0) launch(i, m_hold[i].pop_front());
      else if (acc) launch(i, adata[i]);
      else m_flight[i] = 0;
    end else if (acc) begin
      m_hold[i].push_back(adata[i]);
    end
  endtask

  always @(negedge aclk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("tx_req[%0d]", i),  {31'd0, tx_req[i]},  {31'd0, m_req[i]});
        chk($sformatf("tx_data[%0d]", i), tx_data[i],          m_data[i]);
        chk($sformatf("ardy[%0d]", i),    {31'd0, ardy[i]},    {31'd0, m_ardy(i)});
        chk($sformatf("busy[%0d]", i),    {31'd0, busy[i]},
            {31'd0, (m_flight[i] || m_hold[i].size() > 0)});
        chk($sformatf("ack_err[%0d]", i), {31'd0, ack_err[i]}, {31'd0, m_err[i]});
      end
    end
    for (int i = 0; i < 2; i++) step(i);
    if (arst) m_valid = 1;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  bit rs_busy [2];
  int rs_cnt  [2];
  bit far_seen[2];

  initial begin
    int cyc;
    for (int i = 0; i < 2; i++) begin
      adata[i] = '0; aen[i] = 0; tx_ack[i] = 0;
    end

    // reset and idle
    tick(2);
    arst = 0;
    chk("rst_tx_req",  {31'd0, tx_req[0]}, 32'd0);
    chk("rst_tx_data", tx_data[0], 32'd0);
    chk("rst_ardy",    {31'd0, ardy[0]}, 32'd1);
    chk("rst_busy",    {31'd0, busy[0]}, 32'd0);
    chk("rst_ack_err", {31'd0, ack_err[0]}, 32'd0);
    tick(1);
    tick(3);
    chk("idle_tx_req", {31'd0, tx_req[0]}, 32'd0);
    chk("idle_ardy1",  {31'd0, ardy[1]}, 32'd1);

    // single word
    adata[0] = 32'hDEADBEEF; aen[0] = 1;
    tick(1);
    aen[0] = 0;
    chk("single_data", tx_data[0], 32'hDEADBEEF);
    chk("single_req",  {31'd0, tx_req[0]}, 32'd1);
    chk("single_busy", {31'd0, busy[0]}, 32'd1);
    tx_ack[0] = 1;
    tick(2);
    chk("single_busy_pre_ack", {31'd0, busy[0]}, 32'd1);
    tick(1);
    chk("single_busy_post_ack", {31'd0, busy[0]}, 32'd0);

    // back-to-back into the holding register
    adata[0] = 32'h11; aen[0] = 1;
    tick(1);
    adata[0] = 32'h22;
    tick(1);
    aen[0] = 0;
    chk("b2b_data_first", tx_data[0], 32'h11);
    chk("b2b_ardy_full",  {31'd0, ardy[0]}, 32'd0);
    chk("b2b_req_first",  {31'd0, tx_req[0]}, 32'd0);
    tx_ack[0] = 0;
    tick(2);
    chk("b2b_data_held", tx_data[0], 32'h11);
    tick(1);
    chk("b2b_data_second", tx_data[0], 32'h22);
    chk("b2b_req_second",  {31'd0, tx_req[0]}, 32'd1);
    chk("b2b_ardy_free",   {31'd0, ardy[0]}, 32'd1);
    tx_ack[0] = 1;
    tick(3);
    chk("b2b_idle", {31'd0, busy[0]}, 32'd0);

    // accept on the exact ack cycle with hold empty
    adata[0] = 32'h33; aen[0] = 1;
    tick(1);
    aen[0] = 0;
    chk("same_req_33", {31'd0, tx_req[0]}, 32'd0);
    tx_ack[0] = 0;
    tick(2);
    adata[0] = 32'h44; aen[0] = 1;
    tick(1);
    aen[0] = 0;
    chk("same_data", tx_data[0], 32'h44);
    chk("same_req",  {31'd0, tx_req[0]}, 32'd1);
    chk("same_ardy", {31'd0, ardy[0]}, 32'd1);
    chk("same_busy", {31'd0, busy[0]}, 32'd1);
    tx_ack[0] = 1;
    tick(3);
    chk("same_idle", {31'd0, busy[0]}, 32'd0);

    // no buffer: aen held high
    adata[1] = 32'h55; aen[1] = 1;
    tick(1);
    adata[1] = 32'h66;
    chk("nobuf_data", tx_data[1], 32'h55);
    chk("nobuf_ardy", {31'd0, ardy[1]}, 32'd0);
    tx_ack[1] = 1;
    tick(2);
    chk("nobuf_still_55", tx_data[1], 32'h55);
    tick(1);
    chk("nobuf_idle_ardy", {31'd0, ardy[1]}, 32'd1);
    chk("nobuf_idle_data", tx_data[1], 32'h55);
    tick(1);
    aen[1] = 0;
    chk("nobuf_data_66", tx_data[1], 32'h66);
    chk("nobuf_req_66",  {31'd0, tx_req[1]}, 32'd0);
    tx_ack[1] = 0;
    tick(3);
    chk("nobuf_done", {31'd0, busy[1]}, 32'd0);

    // spurious acknowledge while idle
    tx_ack[0] = 0;
    tick(3);
    chk("spur_err",  {31'd0, ack_err[0]}, 32'd1);
    chk("spur_req",  {31'd0, tx_req[0]}, 32'd1);
    tick(1);
    chk("spur_err_clr", {31'd0, ack_err[0]}, 32'd0);

    // reset with one word in flight and one held
    adata[0] = 32'h77; aen[0] = 1;
    tick(1);
    adata[0] = 32'h88;
    tick(1);
    aen[0] = 0;
    chk("mid_busy", {31'd0, busy[0]}, 32'd1);
    chk("mid_ardy", {31'd0, ardy[0]}, 32'd0);
    arst = 1;
    tick(1);
    arst = 0;
    chk("mid_rst_req",  {31'd0, tx_req[0]}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
    tick(5);
    chk("mid_rst_no88", tx_data[0], 32'd0);

    // randomised traffic with a far-end responder of random latency
    for (int i = 0; i < 2; i++) begin
      acc_q[i].delete(); rx_q[i].delete();
      rs_busy[i] = 0; rs_cnt[i] = 0; far_seen[i] = tx_req[i];
    end
    cyc = 0;
    while (cyc < 30000 && acc_q[0].size() < 1000) begin
      for (int i = 0; i < 2; i++) begin
        aen[i]   = ($urandom_range(0, 99) < 70);
        adata[i] = $urandom;
        if (!rs_busy[i] && tx_req[i] !== far_seen[i]) begin
          rs_busy[i] = 1;
          rs_cnt[i]  = $urandom_range(0, 6);
        end
        if (rs_busy[i]) begin
          if (rs_cnt[i] == 0) begin
            far_seen[i] = tx_req[i];
            rx_q[i].push_back(tx_data[i]);
            tx_ack[i] = !tx_ack[i];
            rs_busy[i] = 0;
          end else begin
            rs_cnt[i]--;
          end
        end
      end
      tick(1);
      cyc++;
    end
    chk("rand_word_budget", {31'd0, (acc_q[0].size() >= 1000)}, 32'd1);

    aen[0] = 0; aen[1] = 0;
    cyc = 0;
    while (cyc < 500 && (m_flight[0] || m_flight[1] || m_hold[0].size() > 0)) begin
      for (int i = 0; i < 2; i++) begin
        if (!rs_busy[i] && tx_req[i] !== far_seen[i]) begin
          rs_busy[i] = 1;
          rs_cnt[i]  = $urandom_range(0, 6);
        end
        if (rs_busy[i]) begin
          if (rs_cnt[i] == 0) begin
            far_seen[i] = tx_req[i];
            rx_q[i].push_back(tx_data[i]);
            tx_ack[i] = !tx_ack[i];
            rs_busy[i] = 0;
          end else begin
            rs_cnt[i]--;
          end
        end
      end
      tick(1);
      cyc++;
    end
    chk("drain_timeout", {31'd0, (cyc < 500)}, 32'd1);
    tick(4);

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("sb_count[%0d]", i), rx_q[i].size(), acc_q[i].size());
      for (int k = 0; k < rx_q[i].size() && k < acc_q[i].size(); k++)
        chk($sformatf("sb_word[%0d][%0d]", i, k), rx_q[i][k], acc_q[i][k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
